// File: rtl/ksa_pkg.sv
// Shared widths, flag bit positions and the generate/propagate bus type for
// the pipelined Kogge-Stone subtractor.
package ksa_pkg;

  localparam int unsigned KSA_WIDTH   = 16;
  localparam int unsigned KSA_LATENCY = 3;

  localparam int unsigned FLAG_ZERO = 0;
  localparam int unsigned FLAG_NEG  = 1;
  localparam int unsigned FLAG_OVF  = 2;

  typedef struct packed {
    logic [KSA_WIDTH-1:0] g;
    logic [KSA_WIDTH-1:0] p;
  } ksa_gp_t;

endpackage

// File: rtl/ksa_prefix_level.sv
// One Kogge-Stone prefix level: lanes at or above DIST merge with the lane
// DIST below them, lower lanes pass through unchanged.
module ksa_prefix_level
  import ksa_pkg::*;
#(
  parameter int unsigned DIST = 1
) (
  input  ksa_gp_t gp_i,
  output ksa_gp_t gp_o
);

  for (genvar i = 0; i < KSA_WIDTH; i++) begin : g_lane
    if (i >= DIST) begin : g_op
      assign gp_o.g[i] = gp_i.g[i] | (gp_i.p[i] & gp_i.g[i-DIST]);
      assign gp_o.p[i] = gp_i.p[i] & gp_i.p[i-DIST];
    end else begin : g_pass
      assign gp_o.g[i] = gp_i.g[i];
      assign gp_o.p[i] = gp_i.p[i];
    end
  end

endmodule

// File: rtl/ksa16_sub_pipe.sv
// Three-stage pipelined 16-bit Kogge-Stone subtractor (a - b - bin) with a
// valid/ready handshake. Define KSA_SUB_FLAGS_EN to compute {ovf, neg, zero}.
module ksa16_sub_pipe
  import ksa_pkg::*;
(
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [KSA_WIDTH-1:0] a,
  input  logic [KSA_WIDTH-1:0] b,
  input  logic                 bin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [KSA_WIDTH-1:0] diff,
  output logic                 bout,
  output logic [2:0]           flags
);

  localparam int unsigned WIDTH = KSA_WIDTH;

  logic             adv;
  logic             cin0;
  ksa_gp_t          gp0, gp1_d, gp1_q, gp3, gp2_d, gp2_q, gp4;
  logic             v1_q, v2_q, out_valid_q;
  logic [WIDTH-1:0] praw1_q, praw2_q;
  logic             cin1_q, cin2_q;
  logic [WIDTH-1:0] diff_d, diff_q, c;
  logic             bout_d, bout_q;
  logic [2:0]       flags_d;

  // Single global enable: the whole pipe advances only if S3 can drain.
  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv;

  // Subtract as add: invert b and the borrow, fold the carry into bit 0.
  always_comb begin
    cin0     = ~bin;
    gp0.g    = a & ~b;
    gp0.p    = a ^ ~b;
    gp0.g[0] = gp0.g[0] | (gp0.p[0] & cin0);
  end

  ksa_prefix_level #(.DIST(1)) u_lvl1 (.gp_i(gp0),   .gp_o(gp1_d));
  ksa_prefix_level #(.DIST(2)) u_lvl2 (.gp_i(gp1_q), .gp_o(gp3));
  ksa_prefix_level #(.DIST(4)) u_lvl3 (.gp_i(gp3),   .gp_o(gp2_d));
  ksa_prefix_level #(.DIST(8)) u_lvl4 (.gp_i(gp2_q), .gp_o(gp4));

`ifdef KSA_SUB_FLAGS_EN
  logic sa1_q, sb1_q, sa2_q, sb2_q;
  logic [2:0] flags_q;
`endif

  // S3 result: carries are the group generates of [i:0].
  always_comb begin
    c       = gp4.g;
    diff_d  = praw2_q ^ {c[WIDTH-2:0], cin2_q};
    bout_d  = ~c[WIDTH-1];
    flags_d = 3'b000;
`ifdef KSA_SUB_FLAGS_EN
    flags_d[FLAG_ZERO] = (diff_d == '0);
    flags_d[FLAG_NEG]  = diff_d[WIDTH-1];
    flags_d[FLAG_OVF]  = (sa2_q ^ sb2_q) & (diff_d[WIDTH-1] ^ sa2_q);
`endif
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      praw1_q     <= '0;
      praw2_q     <= '0;
      cin1_q      <= 1'b0;
      cin2_q      <= 1'b0;
      gp1_q       <= '0;
      gp2_q       <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
    end else if (adv) begin
      v1_q        <= in_valid;
      praw1_q     <= gp0.p;
      cin1_q      <= cin0;
      gp1_q       <= gp1_d;
      v2_q        <= v1_q;
      praw2_q     <= praw1_q;
      cin2_q      <= cin1_q;
      gp2_q       <= gp2_d;
      out_valid_q <= v2_q;
      // Bubbles leave the last result on the outputs.
      if (v2_q) begin
        diff_q <= diff_d;
        bout_q <= bout_d;
      end
    end
  end

`ifdef KSA_SUB_FLAGS_EN
  // Operand sign bits ride along for the signed-overflow flag.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sa1_q   <= 1'b0;
      sb1_q   <= 1'b0;
      sa2_q   <= 1'b0;
      sb2_q   <= 1'b0;
      flags_q <= 3'b000;
    end else if (adv) begin
      sa1_q <= a[WIDTH-1];
      sb1_q <= b[WIDTH-1];
      sa2_q <= sa1_q;
      sb2_q <= sb1_q;
      if (v2_q) flags_q <= flags_d;
    end
  end
  assign flags = flags_q;
`else
  assign flags = flags_d;
`endif

  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule
